// File: rtl/mdr_mem_sequencer.sv
// mdr_mem_sequencer: arbitrates the instruction-fetch port and the data port onto a
// single memory, and steps each transfer through the MDR with load/enable strobes.
// The sequencer never carries data itself. Read data reaches the bus from the MDR, and
// write data is captured from the bus into the MDR.
module mdr_mem_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_RUN     = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic              mdr_lm,
    output logic              mdr_lb,
    output logic              mdr_em,
    output logic              mdr_eb,
    output logic              busy
);

    localparam int RUN_W = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);

    // RD_WAIT lasts WAIT_CYCLES cycles and WR_STRB lasts WAIT_CYCLES+1 cycles.
    // Both states count down to zero from these values.
    localparam logic [3:0] RD_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [3:0] WR_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        RD_LATCH,
        RD_DRIVE,
        WR_CAPT,
        WR_STRB,
        WR_DONE
    } state_t;

    typedef struct packed {
        logic f_ack;
        logic d_ack;
        logic mem_re;
        logic mem_we;
        logic mdr_lm;
        logic mdr_lb;
        logic mdr_em;
        logic mdr_eb;
        logic busy;
    } strobes_t;

    state_t             state;
    strobes_t           outs;
    logic [3:0]         wait_cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic               is_fetch;

    // Moore decode for a state. The register is loaded with the decode of the state
    // being entered, so each output is a flop and no request input reaches an output.
    function automatic strobes_t decode(input state_t s, input logic fetch);
        strobes_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            RD_ADDR, RD_WAIT: o.mem_re = 1'b1;
            RD_LATCH: begin
                o.mem_re = 1'b1;
                o.mdr_lm = 1'b1;
            end
            RD_DRIVE: begin
                o.mdr_eb = 1'b1;
                o.f_ack  = fetch;
                o.d_ack  = !fetch;
            end
            WR_CAPT: o.mdr_lb = 1'b1;
            WR_STRB: begin
                o.mem_we = 1'b1;
                o.mdr_em = 1'b1;
            end
            WR_DONE: o.d_ack = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // This block holds the sequencer state, the grant arbitration, the run and wait counters, and the registered strobes.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            outs     <= '0;
            mem_addr <= '0;
            run_cnt  <= '0;
            wait_cnt <= '0;
            is_fetch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_req && (run_cnt == RUN_LIMIT || !d_req)) begin
                        mem_addr <= f_addr;
                        is_fetch <= 1'b1;
                        run_cnt  <= '0;
                        state    <= RD_ADDR;
                        outs     <= decode(RD_ADDR, 1'b1);
                    end else if (d_req) begin
                        mem_addr <= d_addr;
                        is_fetch <= 1'b0;
                        if (!f_req) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_LIMIT) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                        state <= d_we ? WR_CAPT : RD_ADDR;
                        outs  <= decode(d_we ? WR_CAPT : RD_ADDR, 1'b0);
                    end
                end
                RD_ADDR: begin
                    if (WAIT_CYCLES == 0) begin
                        state <= RD_LATCH;
                        outs  <= decode(RD_LATCH, is_fetch);
                    end else begin
                        wait_cnt <= RD_LOAD;
                        state    <= RD_WAIT;
                        outs     <= decode(RD_WAIT, is_fetch);
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RD_LATCH;
                        outs  <= decode(RD_LATCH, is_fetch);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RD_LATCH: begin
                    state <= RD_DRIVE;
                    outs  <= decode(RD_DRIVE, is_fetch);
                end
                WR_CAPT: begin
                    wait_cnt <= WR_LOAD;
                    state    <= WR_STRB;
                    outs     <= decode(WR_STRB, is_fetch);
                end
                WR_STRB: begin
                    if (wait_cnt == 4'd0) begin
                        state <= WR_DONE;
                        outs  <= decode(WR_DONE, is_fetch);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    outs  <= decode(IDLE, is_fetch);
                end
            endcase
        end
    end

    assign f_ack  = outs.f_ack;
    assign d_ack  = outs.d_ack;
    assign mem_re = outs.mem_re;
    assign mem_we = outs.mem_we;
    assign mdr_lm = outs.mdr_lm;
    assign mdr_lb = outs.mdr_lb;
    assign mdr_em = outs.mdr_em;
    assign mdr_eb = outs.mdr_eb;
    assign busy   = outs.busy;

endmodule

// File: tb/tb_mdr_mem_sequencer.sv
// tb_mdr_mem_sequencer: directed bench for the MDR memory sequencer. It builds a
// behavioural MDR, bus and memory around the WAIT_CYCLES=1 instance. It also drives a
// second WAIT_CYCLES=0 instance for the zero-wait timing.
module tb_mdr_mem_sequencer;

    localparam logic [8:0] O_BUSY = 9'h100;
    localparam logic [8:0] O_FACK = 9'h080;
    localparam logic [8:0] O_DACK = 9'h040;
    localparam logic [8:0] O_RE   = 9'h020;
    localparam logic [8:0] O_WE   = 9'h010;
    localparam logic [8:0] O_LM   = 9'h008;
    localparam logic [8:0] O_LB   = 9'h004;
    localparam logic [8:0] O_EM   = 9'h002;
    localparam logic [8:0] O_EB   = 9'h001;

    typedef struct packed {
        logic       f_req;
        logic [7:0] f_addr;
        logic       d_req;
        logic       d_we;
        logic [7:0] d_addr;
        logic [7:0] host;
        logic [8:0] exp_out;
        logic [7:0] exp_addr;
        logic       chk_bus;
        logic [7:0] exp_bus;
    } vec_t;

    logic       clk;
    logic       clr;
    logic       f_req, d_req, d_we;
    logic [7:0] f_addr, d_addr, host_data;
    logic       f_ack, d_ack, mem_re, mem_we, mdr_lm, mdr_lb, mdr_em, mdr_eb, busy;
    logic [7:0] mem_addr;

    logic       f_req0, d_req0, d_we0;
    logic [7:0] f_addr0, d_addr0;
    logic       f_ack0, d_ack0, mem_re0, mem_we0, mdr_lm0, mdr_lb0, mdr_em0, mdr_eb0, busy0;
    logic [7:0] mem_addr0;

    logic [7:0] mem [0:255];
    logic [7:0] mdr;
    logic [7:0] bus;
    logic [8:0] outs1, outs0;

    int tests;
    int fails;

    mdr_mem_sequencer #(.ADDR_W(8), .WAIT_CYCLES(1), .MAX_RUN(4)) dut (
        .clk(clk), .clr(clr),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mdr_lm(mdr_lm), .mdr_lb(mdr_lb), .mdr_em(mdr_em), .mdr_eb(mdr_eb),
        .busy(busy)
    );

    mdr_mem_sequencer #(.ADDR_W(8), .WAIT_CYCLES(0), .MAX_RUN(4)) dut0 (
        .clk(clk), .clr(clr),
        .f_req(f_req0), .f_addr(f_addr0), .f_ack(f_ack0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_ack(d_ack0),
        .mem_addr(mem_addr0), .mem_re(mem_re0), .mem_we(mem_we0),
        .mdr_lm(mdr_lm0), .mdr_lb(mdr_lb0), .mdr_em(mdr_em0), .mdr_eb(mdr_eb0),
        .busy(busy0)
    );

    assign outs1 = {busy, f_ack, d_ack, mem_re, mem_we, mdr_lm, mdr_lb, mdr_em, mdr_eb};
    assign outs0 = {busy0, f_ack0, d_ack0, mem_re0, mem_we0, mdr_lm0, mdr_lb0, mdr_em0, mdr_eb0};
    assign bus   = mdr_eb ? mdr : host_data;

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural MDR and memory. While clr is high each memory byte is set to addr ^ 8'h5A.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mdr <= 8'h00;
        end else begin
            if (mdr_lm) mdr <= mem[mem_addr];
            else if (mdr_lb) mdr <= bus;
            if (mdr_em && mem_we) mem[mem_addr] <= mdr;
        end
    end

    // Stops the run if it never reaches its summary line.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run still active at t=%0t, required finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input vec_t v);
        f_req     = v.f_req;
        f_addr    = v.f_addr;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        host_data = v.host;
    endtask

    task automatic checkExcl();
        tests++;
        if ($countones({mdr_lm, mdr_lb, mdr_em, mdr_eb}) > 1 || (mem_re && mem_we) ||
            $countones({mdr_lm0, mdr_lb0, mdr_em0, mdr_eb0}) > 1 || (mem_re0 && mem_we0)) begin
            fails++;
            $display("[TB] FAIL strobe_exclusive: outs=%b outs0=%b, required at most one MDR strobe and not re&we",
                     outs1, outs0);
        end
    endtask

    task automatic checkOutput(input string name, input bit sel, input logic [8:0] exp_out,
                               input logic [7:0] exp_addr, input bit chk_bus,
                               input logic [7:0] exp_bus);
        logic [8:0] act;
        logic [7:0] act_addr;
        act      = sel ? outs0 : outs1;
        act_addr = sel ? mem_addr0 : mem_addr;
        tests++;
        if (act !== exp_out || act_addr !== exp_addr || (chk_bus && bus !== exp_bus)) begin
            fails++;
            $display("[TB] FAIL %s: outs=%b addr=%h bus=%h, expected outs=%b addr=%h bus=%h",
                     name, act, act_addr, bus, exp_out, exp_addr, exp_bus);
        end
        checkExcl();
    endtask

    task automatic stepCheck(input string name, input bit sel, input logic [8:0] exp_out,
                             input logic [7:0] exp_addr, input bit chk_bus,
                             input logic [7:0] exp_bus);
        @(posedge clk);
        #1;
        checkOutput(name, sel, exp_out, exp_addr, chk_bus, exp_bus);
    endtask

    vec_t       vecs [10];
    int         n_acks;
    logic [9:0] order;

    // Main directed sequence.
    initial begin
        tests = 0;
        fails = 0;
        clr = 1'b1;
        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; host_data = 0;
        f_req0 = 0; f_addr0 = 0; d_req0 = 0; d_we0 = 0; d_addr0 = 0;

        // Vectors 0-4 are a fetch from 8'h12. Vectors 5-9 are a write of 8'hA5 to 8'h40.
        vecs[0] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, O_BUSY | O_RE,           8'h12, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, O_BUSY | O_RE,           8'h12, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, O_BUSY | O_RE | O_LM,    8'h12, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, O_BUSY | O_EB | O_FACK,  8'h12, 1'b1, 8'h48};
        vecs[4] = '{1'b0, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 9'h000,                  8'h12, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'hA5, O_BUSY | O_LB,           8'h40, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'hA5, O_BUSY | O_WE | O_EM,    8'h40, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'hA5, O_BUSY | O_WE | O_EM,    8'h40, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'hA5, O_BUSY | O_DACK,         8'h40, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 9'h000,                  8'h40, 1'b0, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("reset_dut", 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
        checkOutput("reset_dut0", 1'b1, 9'h000, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].exp_out, vecs[i].exp_addr,
                        vecs[i].chk_bus, vecs[i].exp_bus);
        end
        tests++;
        if (mem[8'h40] !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL write_mem: mem[40]=%h, expected a5", mem[8'h40]);
        end

        // Both ports request continuously. MAX_RUN=4 gives the grant order D,D,D,D,F twice.
        f_req = 1; f_addr = 8'h20; d_req = 1; d_we = 0; d_addr = 8'h30; host_data = 0;
        n_acks = 0;
        order  = '0;
        for (int cyc = 0; cyc < 120 && n_acks < 10; cyc++) begin
            @(posedge clk);
            #1;
            checkExcl();
            if (f_ack || d_ack) begin
                tests++;
                if ((f_ack && d_ack) ||
                    (f_ack && (mem_addr !== 8'h20 || bus !== 8'h7A)) ||
                    (d_ack && (mem_addr !== 8'h30 || bus !== 8'h6A))) begin
                    fails++;
                    $display("[TB] FAIL arb_ack%0d: f_ack=%b d_ack=%b addr=%h bus=%h, expected one ack matching 20/7a or 30/6a",
                             n_acks, f_ack, d_ack, mem_addr, bus);
                end
                order[n_acks] = f_ack;
                n_acks++;
            end
        end
        f_req = 0;
        d_req = 0;
        tests++;
        if (n_acks != 10 || order !== 10'b10_0001_0000) begin
            fails++;
            $display("[TB] FAIL arb_order: acks=%0d order=%b, expected 10 acks order=1000010000",
                     n_acks, order);
        end
        repeat (2) @(posedge clk);
        #1;

        // clr is asserted in the RD_WAIT cycle of a fetch. The fetch then restarts after clr falls.
        f_req = 1; f_addr = 8'h55;
        stepCheck("rst_rdaddr", 1'b0, O_BUSY | O_RE, 8'h55, 1'b0, 8'h00);
        stepCheck("rst_rdwait", 1'b0, O_BUSY | O_RE, 8'h55, 1'b0, 8'h00);
        clr = 1'b1;
        stepCheck("rst_cleared", 1'b0, 9'h000, 8'h00, 1'b0, 8'h00);
        clr = 1'b0;
        stepCheck("rst_restart", 1'b0, O_BUSY | O_RE, 8'h55, 1'b0, 8'h00);
        stepCheck("rst_wait2", 1'b0, O_BUSY | O_RE, 8'h55, 1'b0, 8'h00);
        stepCheck("rst_latch", 1'b0, O_BUSY | O_RE | O_LM, 8'h55, 1'b0, 8'h00);
        stepCheck("rst_drive", 1'b0, O_BUSY | O_EB | O_FACK, 8'h55, 1'b1, 8'h0F);
        f_req = 0;
        stepCheck("rst_idle", 1'b0, 9'h000, 8'h55, 1'b0, 8'h00);

        // The data read address changes and d_req drops right after the grant. The read still completes on 8'h77.
        d_req = 1; d_we = 0; d_addr = 8'h77;
        stepCheck("hold_rdaddr", 1'b0, O_BUSY | O_RE, 8'h77, 1'b0, 8'h00);
        d_req = 0; d_we = 1; d_addr = 8'h10;
        stepCheck("hold_wait", 1'b0, O_BUSY | O_RE, 8'h77, 1'b0, 8'h00);
        stepCheck("hold_latch", 1'b0, O_BUSY | O_RE | O_LM, 8'h77, 1'b0, 8'h00);
        stepCheck("hold_drive", 1'b0, O_BUSY | O_EB | O_DACK, 8'h77, 1'b1, 8'h2D);
        stepCheck("hold_idle1", 1'b0, 9'h000, 8'h77, 1'b0, 8'h00);
        stepCheck("hold_idle2", 1'b0, 9'h000, 8'h77, 1'b0, 8'h00);

        // The WAIT_CYCLES=0 instance skips RD_WAIT and holds WR_STRB for a single cycle.
        f_req0 = 1; f_addr0 = 8'h21;
        stepCheck("w0_rdaddr", 1'b1, O_BUSY | O_RE, 8'h21, 1'b0, 8'h00);
        stepCheck("w0_latch", 1'b1, O_BUSY | O_RE | O_LM, 8'h21, 1'b0, 8'h00);
        stepCheck("w0_drive", 1'b1, O_BUSY | O_EB | O_FACK, 8'h21, 1'b0, 8'h00);
        f_req0 = 0;
        stepCheck("w0_idle", 1'b1, 9'h000, 8'h21, 1'b0, 8'h00);
        d_req0 = 1; d_we0 = 1; d_addr0 = 8'h05;
        stepCheck("w0_capt", 1'b1, O_BUSY | O_LB, 8'h05, 1'b0, 8'h00);
        stepCheck("w0_strb", 1'b1, O_BUSY | O_WE | O_EM, 8'h05, 1'b0, 8'h00);
        stepCheck("w0_done", 1'b1, O_BUSY | O_DACK, 8'h05, 1'b0, 8'h00);
        d_req0 = 0;
        stepCheck("w0_idle2", 1'b1, 9'h000, 8'h05, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
